// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's data port.
// Accepts one load/store at a time and waits WAIT_CYCLES before answering.
// The word array is big-endian: byte offset 0 is bits [31:24].
// Loads return sign- or zero-extended data; stores are read-modify-write.
// Optional feature macro: DMEM_ALIGN_CHECK_EN.
//   Defined: misaligned half/word accesses answer with o_err=1 and o_rdata=0,
//            and do not write the array.
//   Undefined: o_err stays 0, and the address is forced to an aligned one.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;

  logic [31:0]   offset_in;
  logic [AW-1:0] idx_in;
  logic          unused_offset;

  logic [7:0]    byte_lane;
  logic [15:0]   half_lane;
  logic [31:0]   load_val;
  logic [31:0]   store_word;
  logic          misaligned;

  // The address offset from BASE_ADDR wraps modulo the array size.
  // The offset bits above the word index are not used.
  assign offset_in     = i_addr - BASE_ADDR;
  assign idx_in        = offset_in[AW+1:2];
  assign unused_offset = ^offset_in[31:AW+2];

  // Request capture, wait-state countdown and word fetch.
  // When WAIT_CYCLES is 0, the fetch happens on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            idx_q   <= idx_in;
            lane_q  <= offset_in[1:0];
            we_q    <= i_we;
            size_q  <= i_size;
            uns_q   <= i_unsigned;
            wdata_q <= i_wdata;
            if (WAIT_CYCLES == 0) begin
              word_q <= mem[idx_in];
              state  <= ST_RESP;
            end else begin
              count <= CW'(WAIT_CYCLES);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            word_q <= mem[idx_q];
            state  <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The store commits on the edge leaving RESP.
  // A reset clears the state first, so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (state == ST_RESP && we_q && !misaligned) begin
      mem[idx_q] <= store_word;
    end
  end

  // Lane extraction and extension for loads (big-endian lanes).
  always_comb begin
    byte_lane = 8'h00;
    case (lane_q)
      2'd0:    byte_lane = word_q[31:24];
      2'd1:    byte_lane = word_q[23:16];
      2'd2:    byte_lane = word_q[15:8];
      default: byte_lane = word_q[7:0];
    endcase
    half_lane = lane_q[1] ? word_q[15:0] : word_q[31:16];
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{~uns_q & half_lane[15]}}, half_lane};
      default: load_val = word_q;
    endcase
  end

  // Merge the store data into the fetched word.
  // Lanes that are not addressed keep their old value.
  always_comb begin
    store_word = word_q;
    case (size_q)
      2'b00: begin
        case (lane_q)
          2'd0:    store_word[31:24] = wdata_q[7:0];
          2'd1:    store_word[23:16] = wdata_q[7:0];
          2'd2:    store_word[15:8]  = wdata_q[7:0];
          default: store_word[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (lane_q[1]) store_word[15:0]  = wdata_q[15:0];
        else           store_word[31:16] = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  // Misalignment detection, present only when the alignment check is built in.
`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = ((size_q == 2'b01) && lane_q[0]) ||
                 (size_q[1] && (lane_q != 2'b00));
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  assign o_ready = (state == ST_IDLE);
  assign o_ack   = (state == ST_RESP);
  assign o_err   = o_ack & misaligned;
  assign o_rdata = (o_ack && !misaligned) ? load_val : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// Two instances share the request inputs: one uses the default of 2 wait states,
// and the other uses 0 wait states. Both should hold identical array contents.
// Misalignment expectations follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        ready, ack, err;
  logic [31:0] rdata;
  logic        ready0, ack0, err0;
  logic [31:0] rdata0;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic        MIS_ERR  = 1'b1;
  localparam logic [31:0] MIS_LW   = 32'h0000_0000;
  localparam logic [31:0] MIS_LH   = 32'h0000_0000;
  localparam logic [31:0] AFTER_SW = 32'h8001_5678;
`else
  localparam logic        MIS_ERR  = 1'b0;
  localparam logic [31:0] MIS_LW   = 32'h8001_5678;
  localparam logic [31:0] MIS_LH   = 32'hFFFF_8001;
  localparam logic [31:0] AFTER_SW = 32'h5555_5555;
`endif

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready), .o_ack(ack), .o_rdata(rdata), .o_err(err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_zero (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready0), .o_ack(ack0), .o_rdata(rdata0), .o_err(err0)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request to both instances. Then wait a bounded number of cycles
  // for the slower instance to ack. Cycle 1 is the cycle after the accept edge.
  task automatic applyStimulus(input logic we_in, input logic [1:0] size_in,
                               input logic uns_in, input logic [31:0] addr_in,
                               input logic [31:0] wdata_in,
                               output logic [31:0] rd_main, output logic err_main,
                               output int lat_main, output logic [31:0] rd_zero,
                               output logic err_zero, output int lat_zero,
                               output logic ready_bad);
    rd_main = '0; err_main = 1'b0; lat_main = 0;
    rd_zero = '0; err_zero = 1'b0; lat_zero = 0;
    ready_bad = 1'b0;
    @(negedge clk);
    req = 1'b1; we = we_in; size = size_in; uns = uns_in;
    addr = addr_in; wdata = wdata_in;
    for (int cyc = 1; cyc <= 20 && lat_main == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        req = 1'b0;
        addr = 32'hFFFF_FFFF;
        wdata = 32'h0BAD_0BAD;
      end
      if (ready) ready_bad = 1'b1;
      if (ack0 && lat_zero == 0) begin
        lat_zero = cyc; rd_zero = rdata0; err_zero = err0;
      end
      if (ack) begin
        lat_main = cyc; rd_main = rdata; err_main = err;
      end
    end
  endtask

  task automatic runAccess(input string tag, input logic we_in,
                           input logic [1:0] size_in, input logic uns_in,
                           input logic [31:0] addr_in, input logic [31:0] wdata_in,
                           input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd_m, rd_z;
    logic        er_m, er_z, rbad;
    int          lat_m, lat_z;
    applyStimulus(we_in, size_in, uns_in, addr_in, wdata_in,
                  rd_m, er_m, lat_m, rd_z, er_z, lat_z, rbad);
    checkOutput({tag, "_lat"}, 32'(lat_m), 32'd3);
    checkOutput({tag, "_lat0"}, 32'(lat_z), 32'd1);
    checkOutput({tag, "_ready_low"}, {31'b0, rbad}, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, er_m}, {31'b0, exp_err});
    checkOutput({tag, "_err0"}, {31'b0, er_z}, {31'b0, exp_err});
    if (!we_in) begin
      checkOutput({tag, "_rdata"}, rd_m, exp_rdata);
      checkOutput({tag, "_rdata0"}, rd_z, exp_rdata);
    end
  endtask

  // Directed sequence.
  initial begin
    logic [31:0] mask_main, mask_zero;
    int          bad_data, ack_seen;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'b0, ready}, 32'd1);
    checkOutput("rst_ack", {31'b0, ack}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_ready0", {31'b0, ready0}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    runAccess("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
    runAccess("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

    runAccess("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h0, 1'b0);
    runAccess("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h12AB_5678, 1'b0);
    runAccess("lb_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0);
    runAccess("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00AB, 1'b0);

    runAccess("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_5678, 1'b0);
    runAccess("sh_10", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_8001, 32'h0, 1'b0);
    runAccess("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_8001, 1'b0);
    runAccess("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_8001, 1'b0);
    runAccess("lw_10c", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h8001_5678, 1'b0);

    runAccess("sw_wrap", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
    runAccess("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Hold the request high for 12 cycles. The slow instance acks every 4th cycle,
    // and the zero-wait instance acks every 2nd cycle.
    mask_main = '0; mask_zero = '0; bad_data = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (ack) begin
        mask_main[cyc-1] = 1'b1;
        if (rdata !== 32'hDEAD_BEEF) bad_data++;
      end
      if (ack0) begin
        mask_zero[cyc-1] = 1'b1;
        if (rdata0 !== 32'hDEAD_BEEF) bad_data++;
      end
    end
    req = 1'b0;
    checkOutput("hold_acks", mask_main, 32'h0000_0444);
    checkOutput("hold_acks0", mask_zero, 32'h0000_0555);
    checkOutput("hold_data", 32'(bad_data), 32'd0);

    // A reset during WAIT discards the pending store. The zero-wait copy is
    // in RESP at that moment, so its store is also discarded.
    runAccess("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0;
    addr = 32'h20; wdata = 32'h1111_1111;
    @(negedge clk);
    req = 1'b0;
    checkOutput("mid_ready_low", {31'b0, ready}, 32'd0);
    rst_n = 1'b0;
    ack_seen = 0;
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'b0, ready}, 32'd1);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    checkOutput("mid_rst_no_ack", 32'(ack_seen), 32'd0);
    runAccess("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Misaligned accesses.
    runAccess("lw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, MIS_LW, MIS_ERR);
    runAccess("lh_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, MIS_LH, MIS_ERR);
    runAccess("sw_13", 1'b1, 2'b10, 1'b0, 32'h13, 32'h5555_5555, 32'h0, MIS_ERR);
    runAccess("lw_10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, AFTER_SW, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
